fnd_scan_controller: RTL and testbench

//   Time-multiplexed scan sequencer for the 4-digit common-anode FND. Cycles digit position 0..3,

---
 rtl/fnd_scan_controller_pkg.sv | 29 ++
 rtl/fnd_scan_controller_prescaler.sv | 27 ++
 rtl/fnd_scan_controller.sv | 153 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// rtl/fnd_scan_controller_pkg.sv - shared FSM states, digit positions and common encodings for the FND scanner
package fnd_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [1:0] DIGIT_ONES      = 2'd0;
  localparam logic [1:0] DIGIT_TENS      = 2'd1;
  localparam logic [1:0] DIGIT_HUNDREDS  = 2'd2;
  localparam logic [1:0] DIGIT_THOUSANDS = 2'd3;

  localparam logic [3:0] COM_ALL_OFF = 4'b1111;

  // Active-low one-cold common for a digit position.
  function automatic logic [3:0] com_select(input logic [1:0] digit);
    logic [3:0] com;
    case (digit)
      DIGIT_ONES:     com = 4'b1110;
      DIGIT_TENS:     com = 4'b1101;
      DIGIT_HUNDREDS: com = 4'b1011;
      default:        com = 4'b0111;
    endcase
    return com;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_prescaler.sv
// rtl/fnd_scan_controller_prescaler.sv - slot-rate divider, counts 0..DIV-1 and flags the last cycle
module fnd_scan_controller_prescaler #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (r_count == CW'(DIV - 1)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick = (r_count == CW'(DIV - 1));

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan sequencer with per-frame snapshot; option FND_LEADING_ZERO_BLANK_EN
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_1000_value,
  input  logic [3:0] i_100_value,
  input  logic [3:0] i_10_value,
  input  logic [3:0] i_1_value,
  output logic [1:0] o_digitPosition,
  output logic [3:0] o_fndCom,
  output logic [3:0] o_1000_value,
  output logic [3:0] o_100_value,
  output logic [3:0] o_10_value,
  output logic [3:0] o_1_value,
  output logic       o_frame_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int BW  = $clog2(BLANK_CYCLES) + 1;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_tick;
  logic          w_clear;
  logic          w_lit;
  logic [BW-1:0] r_blank_cnt;
  logic [1:0]    r_digit;
  logic [3:0]    r_com;
  logic [3:0]    w_com_next;
  logic [3:0]    r_snap_1000;
  logic [3:0]    r_snap_100;
  logic [3:0]    r_snap_10;
  logic [3:0]    r_snap_1;
  logic          r_frame_tick;

  // Prescaler sits at 0 while idle so the first slot after enable is full length.
  assign w_clear = !i_enable || (r_state == ST_IDLE);

  fnd_scan_controller_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_BLANK;
        ST_BLANK: begin
          if (w_tick) begin
            w_state_next = ST_BLANK;
          end else if (r_blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            w_state_next = ST_ON;
          end
        end
        ST_ON:    if (w_tick) w_state_next = ST_BLANK;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_lit = 1'b1;
    case (r_digit)
      DIGIT_TENS:      w_lit = |{r_snap_1000, r_snap_100, r_snap_10};
      DIGIT_HUNDREDS:  w_lit = |{r_snap_1000, r_snap_100};
      DIGIT_THOUSANDS: w_lit = |r_snap_1000;
      default:         w_lit = 1'b1;
    endcase
  end
`else
  assign w_lit = 1'b1;
`endif

  // ON is only ever entered without a slot change, so the current digit is the next digit.
  always_comb begin
    w_com_next = COM_ALL_OFF;
    if (w_state_next == ST_ON && w_lit) begin
      w_com_next = com_select(r_digit);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blank_cnt  <= '0;
      r_digit      <= DIGIT_ONES;
      r_com        <= COM_ALL_OFF;
      r_snap_1000  <= '0;
      r_snap_100   <= '0;
      r_snap_10    <= '0;
      r_snap_1     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_com        <= w_com_next;
      r_frame_tick <= 1'b0;
      if (!i_enable) begin
        r_blank_cnt <= '0;
        r_digit     <= DIGIT_ONES;
      end else if (r_state == ST_IDLE) begin
        r_blank_cnt  <= '0;
        r_digit      <= DIGIT_ONES;
        r_snap_1000  <= i_1000_value;
        r_snap_100   <= i_100_value;
        r_snap_10    <= i_10_value;
        r_snap_1     <= i_1_value;
        r_frame_tick <= 1'b1;
      end else if (w_tick) begin
        r_blank_cnt <= '0;
        r_digit     <= r_digit + 2'd1;
        if (r_digit == DIGIT_THOUSANDS) begin
          r_snap_1000  <= i_1000_value;
          r_snap_100   <= i_100_value;
          r_snap_10    <= i_10_value;
          r_snap_1     <= i_1_value;
          r_frame_tick <= 1'b1;
        end
      end else if (r_state == ST_BLANK) begin
        r_blank_cnt <= r_blank_cnt + BW'(1);
      end
    end
  end

  assign o_digitPosition = r_digit;
  assign o_fndCom        = r_com;
  assign o_1000_value    = r_snap_1000;
  assign o_100_value     = r_snap_100;
  assign o_10_value      = r_snap_10;
  assign o_1_value       = r_snap_1;
  assign o_frame_tick    = r_frame_tick;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - directed self-checking bench for fnd_scan_controller (DIV=10, BLANK_CYCLES=2)
module tb_fnd_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] v1000, v100, v10, v1;
  logic [1:0] pos;
  logic [3:0] com;
  logic [3:0] s1000, s100, s10, s1;
  logic       tick;

  int checks = 0;
  int errors = 0;

`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .BLANK_CYCLES(2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_1000_value   (v1000),
    .i_100_value    (v100),
    .i_10_value     (v10),
    .i_1_value      (v1),
    .o_digitPosition(pos),
    .o_fndCom       (com),
    .o_1000_value   (s1000),
    .o_100_value    (s100),
    .o_10_value     (s10),
    .o_1_value      (s1),
    .o_frame_tick   (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    v1000 = 4'd1; v100 = 4'd2; v10 = 4'd3; v1 = 4'd4;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (com !== 4'b1111) begin errors++; $display("FAIL reset_com cyc=%0d got=%b exp=1111", i, com); end
      checks++;
      if (pos !== 2'd0) begin errors++; $display("FAIL reset_pos cyc=%0d got=%0d exp=0", i, pos); end
      checks++;
      if ({s1000, s100, s10, s1} !== 16'h0000) begin errors++; $display("FAIL reset_snap cyc=%0d got=%h exp=0000", i, {s1000, s100, s10, s1}); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick cyc=%0d got=%b exp=0", i, tick); end
    end
  endtask

  // Cycle c counts edges since enable; cycle 0 is the first cycle after the enable edge.
  task automatic test_scan();
    logic [3:0] exp_com;
    int slot, p;
    enable = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step();
      slot = (c / 10) % 4; p = c % 10;
      exp_com = 4'b1111;
      if (p >= 2) exp_com = ~(4'b0001 << slot);
      checks++;
      if (com !== exp_com) begin errors++; $display("FAIL scan_com c=%0d got=%b exp=%b", c, com, exp_com); end
      checks++;
      if (pos !== 2'(slot)) begin errors++; $display("FAIL scan_pos c=%0d got=%0d exp=%0d", c, pos, slot); end
      checks++;
      if (tick !== (c % 40 == 0)) begin errors++; $display("FAIL scan_tick c=%0d got=%b exp=%b", c, tick, (c % 40 == 0)); end
      checks++;
      if ({s1000, s100, s10, s1} !== 16'h1234) begin errors++; $display("FAIL scan_snap c=%0d got=%h exp=1234", c, {s1000, s100, s10, s1}); end
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] exp_snap;
    logic [3:0]  exp_com;
    int slot, p;
    for (int c = 80; c < 126; c++) begin
      if (c == 85) begin v1000 = 4'd9; v100 = 4'd8; v10 = 4'd7; v1 = 4'd6; end
      step();
      slot = (c / 10) % 4; p = c % 10;
      exp_com = 4'b1111;
      if (p >= 2) exp_com = ~(4'b0001 << slot);
      exp_snap = (c < 120) ? 16'h1234 : 16'h9876;
      checks++;
      if ({s1000, s100, s10, s1} !== exp_snap) begin errors++; $display("FAIL snap_hold c=%0d got=%h exp=%h", c, {s1000, s100, s10, s1}, exp_snap); end
      checks++;
      if (tick !== (c == 80 || c == 120)) begin errors++; $display("FAIL snap_tick c=%0d got=%b exp=%b", c, tick, (c == 80 || c == 120)); end
      checks++;
      if (com !== exp_com) begin errors++; $display("FAIL snap_com c=%0d got=%b exp=%b", c, com, exp_com); end
    end
  endtask

  task automatic test_disable();
    for (int c = 126; c <= 145; c++) step();
    checks++;
    if (com !== 4'b1011) begin errors++; $display("FAIL dis_pre_com got=%b exp=1011", com); end
    checks++;
    if (pos !== 2'd2) begin errors++; $display("FAIL dis_pre_pos got=%0d exp=2", pos); end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (com !== 4'b1111) begin errors++; $display("FAIL dis_com i=%0d got=%b exp=1111", i, com); end
      checks++;
      if (pos !== 2'd0) begin errors++; $display("FAIL dis_pos i=%0d got=%0d exp=0", i, pos); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL dis_tick i=%0d got=%b exp=0", i, tick); end
      if (i == 2) begin v1000 = 4'd5; v100 = 4'd5; v10 = 4'd5; v1 = 4'd5; end
    end
    checks++;
    if ({s1000, s100, s10, s1} !== 16'h9876) begin errors++; $display("FAIL dis_snap_held got=%h exp=9876", {s1000, s100, s10, s1}); end
    enable = 1'b1;
    step();
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL reen_tick got=%b exp=1", tick); end
    checks++;
    if ({s1000, s100, s10, s1} !== 16'h5555) begin errors++; $display("FAIL reen_snap got=%h exp=5555", {s1000, s100, s10, s1}); end
    checks++;
    if (com !== 4'b1111 || pos !== 2'd0) begin errors++; $display("FAIL reen_first got=%b/%0d exp=1111/0", com, pos); end
    step(); step();
    checks++;
    if (com !== 4'b1110 || tick !== 1'b0) begin errors++; $display("FAIL reen_on got=%b/%b exp=1110/0", com, tick); end
  endtask

  task automatic test_reset_mid();
    repeat (13) step();
    checks++;
    if (com !== 4'b1101 || pos !== 2'd1) begin errors++; $display("FAIL rst_pre got=%b/%0d exp=1101/1", com, pos); end
    reset = 1'b1;
    step();
    checks++;
    if (com !== 4'b1111 || pos !== 2'd0 || tick !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b/%0d/%b exp=1111/0/0", com, pos, tick); end
    checks++;
    if ({s1000, s100, s10, s1} !== 16'h0000) begin errors++; $display("FAIL rst_mid_snap got=%h exp=0000", {s1000, s100, s10, s1}); end
    reset = 1'b0;
    step();
    checks++;
    if (tick !== 1'b1 || {s1000, s100, s10, s1} !== 16'h5555) begin errors++; $display("FAIL rst_restart got=%b/%h exp=1/5555", tick, {s1000, s100, s10, s1}); end
    checks++;
    if (com !== 4'b1111 || pos !== 2'd0) begin errors++; $display("FAIL rst_restart_com got=%b/%0d exp=1111/0", com, pos); end
    step(); step();
    checks++;
    if (com !== 4'b1110) begin errors++; $display("FAIL rst_restart_on got=%b exp=1110", com); end
  endtask

  task automatic test_leading_zero(input logic [3:0] d3, input logic [3:0] d2,
                                   input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] d [4];
    logic [3:0] exp_com;
    logic       lit;
    int slot, p;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    enable = 1'b0;
    step();
    v1000 = d3; v100 = d2; v10 = d1; v1 = d0;
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      slot = c / 10; p = c % 10;
      lit = !LZB || (slot == 0);
      for (int k = slot; k < 4; k++) if (d[k] != 4'd0) lit = 1'b1;
      exp_com = 4'b1111;
      if (p >= 2 && lit) exp_com = ~(4'b0001 << slot);
      checks++;
      if (com !== exp_com) begin errors++; $display("FAIL lz_com in=%h%h%h%h c=%0d got=%b exp=%b", d3, d2, d1, d0, c, com, exp_com); end
      checks++;
      if (pos !== 2'(slot)) begin errors++; $display("FAIL lz_pos c=%0d got=%0d exp=%0d", c, pos, slot); end
      if (c == 0) begin
        checks++;
        if ({s1000, s100, s10, s1} !== {d3, d2, d1, d0}) begin errors++; $display("FAIL lz_snap got=%h exp=%h", {s1000, s100, s10, s1}, {d3, d2, d1, d0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_disable();
    test_reset_mid();
    test_leading_zero(4'd0, 4'd0, 4'd4, 4'd2);
    test_leading_zero(4'd0, 4'd0, 4'd0, 4'd0);
    test_leading_zero(4'd0, 4'd7, 4'd0, 4'd0);
    test_leading_zero(4'hF, 4'hA, 4'hC, 4'hB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
